// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory responder.
// State encoding, default widths, index sizing and latency counter width.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int LAT_CNT_W  = 4;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with a registered read port.
// Contents are never reset; only the read register is.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**IDX_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage write port; no reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register holds its value until the next read or a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Target side of the CPU memory request interface with fixed access latency.
// Define MEM_ALIGN_CHECK_EN to add resp_err and suppress misaligned accesses.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              resp_err,
`endif
    output logic              busy
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int LO_W  = IDX_W + 2;

    mem_state_t           state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 wr_q;
    logic [LO_W-1:0]      lo_q;
    logic [DATA_W-1:0]    wdata_q;

    logic                 latch;
    logic                 acc;
    logic                 acc_wr;
    logic                 acc_mis;
    logic [LO_W-1:0]      acc_lo;
    logic [DATA_W-1:0]    acc_wdata;

    logic                 mem_we;
    logic                 mem_re;
    logic                 mem_clr;
    logic                 unused_ok;

    // Next state, latency count and access selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        acc       = 1'b0;
        acc_wr    = wr_q;
        acc_lo    = lo_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    latch = 1'b1;
                    if (LATENCY == 0) begin
                        // Zero latency: access straight from the request.
                        acc       = 1'b1;
                        acc_wr    = req_write;
                        acc_lo    = req_addr[LO_W-1:0];
                        acc_wdata = req_wdata;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = LAT_CNT_W'(LATENCY);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAT_CNT_W'(1)) begin
                    acc     = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign acc_mis = (acc_lo[1:0] != 2'b00);
`else
    assign acc_mis = 1'b0;
`endif

    assign mem_we  = acc & acc_wr & ~acc_mis;
    assign mem_re  = acc & ~acc_wr & ~acc_mis;
    assign mem_clr = acc & ~acc_wr & acc_mis;

    // State, counter and request capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            lo_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                wr_q    <= req_write;
                lo_q    <= req_addr[LO_W-1:0];
                wdata_q <= req_wdata;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    // Error flag is set on the access edge so it lines up with resp_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= acc & acc_mis;
        end
    end

    assign resp_err = err_q;
`endif

    mem_array #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .clr_i   (mem_clr),
        .idx_i   (acc_lo[LO_W-1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (resp_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);

    // Upper address bits wrap; byte offset matters only with the check.
    assign unused_ok = ^{req_addr[ADDR_W-1:LO_W], acc_lo[1:0]};

endmodule
